// File: rtl/immediate_generator_pipe.sv
// Decodes a RISC-V immediate from the opcode and buffers it in a DEPTH-entry FIFO.
// Result is visible one cycle after the push; In_Ready drops when full, and a pop does not free a slot until the next cycle.
module immediate_generator_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [31:0]      instruction_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [XLEN-1:0]  immediate_o,
  output logic [2:0]       format_o,
  output logic [CNT_W-1:0] decoded_count_o
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  logic [6:0]      opcode;
  logic [31:0]     dec_imm32;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0] imm_mem_q [DEPTH];
  logic [2:0]      fmt_mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [CNT_W-1:0] decoded_cnt_q, decoded_cnt_d;

  logic full, empty, push, pop;

  assign opcode = instruction_i[6:0];

  // Each format is built at 32 bits already sign-extended, then widened to XLEN.
  always_comb begin
    dec_fmt   = FMT_NONE;
    dec_imm32 = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                     instruction_i[30:25], instruction_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {instruction_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                     instruction_i[20], instruction_i[30:21], 1'b0};
      end
      default: begin
        dec_fmt   = FMT_NONE;
        dec_imm32 = '0;
      end
    endcase
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  assign full        = (count_q == (PW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign in_ready_o  = !full && !rst_i;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign immediate_o     = empty ? '0 : imm_mem_q[rd_ptr_q];
  assign format_o        = empty ? FMT_NONE : fmt_mem_q[rd_ptr_q];
  assign decoded_count_o = decoded_cnt_q;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + (PW+1)'(push) - (PW+1)'(pop);
    decoded_cnt_d = decoded_cnt_q;
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PW'(1);
      decoded_cnt_d = decoded_cnt_q + CNT_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    // Flush drops the same-cycle push but the pop above has already been counted.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      decoded_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      decoded_cnt_q <= decoded_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      imm_mem_q[wr_ptr_q] <= dec_imm;
      fmt_mem_q[wr_ptr_q] <= dec_fmt;
    end
  end

endmodule
